// File: rtl/open_list_pq.sv
// rtl/open_list_pq.sv - sorted-register min-priority queue for A* open-list nodes
// Head (slot 0) is always the lowest f; supports same-cycle pop+insert and coordinate dedup.
module open_list_pq #(
  parameter int QUEUE_SIZE = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAP_WIDTH  = 16,
  parameter int MAP_HEIGHT = 16,
  parameter int DEDUP      = 1,
  localparam int CW        = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_clear,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_node_f,
  input  logic [MAP_WIDTH-1:0]  i_node_i,
  input  logic [MAP_HEIGHT-1:0] i_node_j,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_node_f,
  output logic [MAP_WIDTH-1:0]  o_node_i,
  output logic [MAP_HEIGHT-1:0] o_node_j,
  output logic [CW-1:0]         o_count,
  output logic                  o_drop,
  output logic                  o_updated
);

  typedef struct packed {
    logic                  v;
    logic [DATA_WIDTH-1:0] f;
    logic [MAP_WIDTH-1:0]  i;
    logic [MAP_HEIGHT-1:0] j;
  } slot_t;

  slot_t           slot_q [QUEUE_SIZE];
  slot_t           slot_d [QUEUE_SIZE];
  logic [CW-1:0]   count_q, count_d;
  logic            drop_q, drop_d;
  logic            upd_q, upd_d;

  slot_t           ext_s  [QUEUE_SIZE+1];
  slot_t           rem_s  [QUEUE_SIZE+1];
  // kept_s is offset by one so slot s can pick its left neighbour at index s
  slot_t           kept_s [QUEUE_SIZE+1];
  slot_t           ins_node;
  logic            pop, hit, hit_lower, do_insert, do_remove;
  logic [DATA_WIDTH-1:0] hit_f;
  logic [CW-1:0]   rem_count;
  int              hit_idx;
  int              ins_pos;

  always_comb begin
    ins_node  = {1'b1, i_node_f, i_node_i, i_node_j};
    pop       = i_read && (count_q != '0);
    rem_count = count_q - CW'(pop);

    for (int s = 0; s < QUEUE_SIZE; s++) ext_s[s] = slot_q[s];
    ext_s[QUEUE_SIZE] = '0;
    for (int s = 0; s < QUEUE_SIZE; s++) rem_s[s] = pop ? ext_s[s+1] : ext_s[s];
    rem_s[QUEUE_SIZE] = '0;

    hit     = 1'b0;
    hit_idx = 0;
    hit_f   = '0;
    if (DEDUP != 0) begin
      for (int s = 0; s < QUEUE_SIZE; s++) begin
        if (!hit && rem_s[s].v && rem_s[s].i == i_node_i && rem_s[s].j == i_node_j) begin
          hit     = 1'b1;
          hit_idx = s;
          hit_f   = rem_s[s].f;
        end
      end
    end

    hit_lower = hit && (i_node_f < hit_f);
    do_remove = i_wrt && hit_lower;
    do_insert = i_wrt && (hit ? hit_lower : (rem_count != CW'(QUEUE_SIZE)));
    drop_d    = i_wrt && !do_insert;
    upd_d     = do_remove;

    kept_s[0] = '0;
    for (int s = 0; s < QUEUE_SIZE; s++)
      kept_s[s+1] = (do_remove && s >= hit_idx) ? rem_s[s+1] : rem_s[s];

    // Entries are sorted and compacted, so counting f <= new gives the FIFO-stable slot
    ins_pos = 0;
    for (int s = 0; s < QUEUE_SIZE; s++)
      if (kept_s[s+1].v && kept_s[s+1].f <= i_node_f) ins_pos = ins_pos + 1;

    for (int s = 0; s < QUEUE_SIZE; s++) begin
      if (!do_insert || s < ins_pos) slot_d[s] = kept_s[s+1];
      else if (s == ins_pos)         slot_d[s] = ins_node;
      else                           slot_d[s] = kept_s[s];
    end
    count_d = rem_count + CW'(do_insert && !do_remove);

    if (i_clear) begin
      for (int s = 0; s < QUEUE_SIZE; s++) slot_d[s] = '0;
      count_d = '0;
      drop_d  = 1'b0;
      upd_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int s = 0; s < QUEUE_SIZE; s++) slot_q[s] <= '0;
      count_q <= '0;
      drop_q  <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      for (int s = 0; s < QUEUE_SIZE; s++) slot_q[s] <= slot_d[s];
      count_q <= count_d;
      drop_q  <= drop_d;
      upd_q   <= upd_d;
    end
  end

  assign o_empty   = (count_q == '0);
  assign o_full    = (count_q == CW'(QUEUE_SIZE));
  assign o_valid   = (count_q != '0);
  assign o_node_f  = slot_q[0].f;
  assign o_node_i  = slot_q[0].i;
  assign o_node_j  = slot_q[0].j;
  assign o_count   = count_q;
  assign o_drop    = drop_q;
  assign o_updated = upd_q;

endmodule

// File: tb/tb_open_list_pq.sv
// tb/tb_open_list_pq.sv - bench for open_list_pq: three configurations against a queue model
// Instance 0: 16 deep dedup, 1: 4 deep dedup, 2: 8 deep no dedup; all share one stimulus stream.
module tb_open_list_pq;

  typedef struct packed {
    logic [31:0] f;
    logic [15:0] i;
    logic [15:0] j;
  } node_t;

  localparam int QN [3] = '{16, 4, 8};
  localparam int QD [3] = '{1, 1, 0};

  logic        CLK, RSTn, clr, wr, rd;
  logic [31:0] nf;
  logic [15:0] ni, nj;
  logic        emp [3];
  logic        full [3];
  logic        vld [3];
  logic        drp [3];
  logic        upd [3];
  logic [31:0] hf [3];
  logic [15:0] hi [3];
  logic [15:0] hj [3];
  logic [4:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [3:0]  cnt_c;

  int    checks = 0;
  int    failures = 0;
  bit    run_cmp = 0;
  node_t mq [3][$];
  int    exp_drop [3] = '{0, 0, 0};
  int    exp_upd  [3] = '{0, 0, 0};

  open_list_pq #(.QUEUE_SIZE(16), .DEDUP(1)) dut_a (
    .CLK(CLK), .RSTn(RSTn), .i_clear(clr), .i_wrt(wr), .i_read(rd),
    .i_node_f(nf), .i_node_i(ni), .i_node_j(nj),
    .o_empty(emp[0]), .o_full(full[0]), .o_valid(vld[0]),
    .o_node_f(hf[0]), .o_node_i(hi[0]), .o_node_j(hj[0]),
    .o_count(cnt_a), .o_drop(drp[0]), .o_updated(upd[0]));

  open_list_pq #(.QUEUE_SIZE(4), .DEDUP(1)) dut_b (
    .CLK(CLK), .RSTn(RSTn), .i_clear(clr), .i_wrt(wr), .i_read(rd),
    .i_node_f(nf), .i_node_i(ni), .i_node_j(nj),
    .o_empty(emp[1]), .o_full(full[1]), .o_valid(vld[1]),
    .o_node_f(hf[1]), .o_node_i(hi[1]), .o_node_j(hj[1]),
    .o_count(cnt_b), .o_drop(drp[1]), .o_updated(upd[1]));

  open_list_pq #(.QUEUE_SIZE(8), .DEDUP(0)) dut_c (
    .CLK(CLK), .RSTn(RSTn), .i_clear(clr), .i_wrt(wr), .i_read(rd),
    .i_node_f(nf), .i_node_i(ni), .i_node_j(nj),
    .o_empty(emp[2]), .o_full(full[2]), .o_valid(vld[2]),
    .o_node_f(hf[2]), .o_node_i(hi[2]), .o_node_j(hj[2]),
    .o_count(cnt_c), .o_drop(drp[2]), .o_updated(upd[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int act_cnt(int d);
    case (d)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      default: return int'(cnt_c);
    endcase
  endfunction

  function automatic void model_ins(int d, node_t nd);
    int k = 0;
    while (k < mq[d].size() && mq[d][k].f <= nd.f) k++;
    mq[d].insert(k, nd);
  endfunction

  function automatic void model_step(int d);
    node_t nd;
    int    m;
    exp_drop[d] = 0;
    exp_upd[d]  = 0;
    if (clr) begin
      mq[d].delete();
      return;
    end
    if (rd && mq[d].size() > 0) void'(mq[d].pop_front());
    if (!wr) return;
    nd = {nf, ni, nj};
    m  = -1;
    if (QD[d] != 0)
      for (int k = 0; k < mq[d].size(); k++)
        if (m < 0 && mq[d][k].i == ni && mq[d][k].j == nj) m = k;
    if (m >= 0) begin
      if (nf < mq[d][m].f) begin
        mq[d].delete(m);
        model_ins(d, nd);
        exp_upd[d] = 1;
      end else begin
        exp_drop[d] = 1;
      end
    end else if (mq[d].size() >= QN[d]) begin
      exp_drop[d] = 1;
    end else begin
      model_ins(d, nd);
    end
  endfunction

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int d = 0; d < 3; d++) begin
        mq[d].delete();
        exp_drop[d] = 0;
        exp_upd[d]  = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) model_step(d);
    end
  end

  always @(negedge CLK) begin
    if (run_cmp) begin
      for (int d = 0; d < 3; d++) begin
        node_t h;
        int    n;
        n = mq[d].size();
        h = (n > 0) ? mq[d][0] : '0;
        chk($sformatf("cmp%0d_count", d), 64'(act_cnt(d)), 64'(n));
        chk($sformatf("cmp%0d_empty", d), 64'(emp[d]), 64'(n == 0));
        chk($sformatf("cmp%0d_full", d),  64'(full[d]), 64'(n == QN[d]));
        chk($sformatf("cmp%0d_valid", d), 64'(vld[d]), 64'(n != 0));
        chk($sformatf("cmp%0d_head_f", d), 64'(hf[d]), 64'(h.f));
        chk($sformatf("cmp%0d_head_i", d), 64'(hi[d]), 64'(h.i));
        chk($sformatf("cmp%0d_head_j", d), 64'(hj[d]), 64'(h.j));
        chk($sformatf("cmp%0d_drop", d),  64'(drp[d]), 64'(exp_drop[d]));
        chk($sformatf("cmp%0d_upd", d),   64'(upd[d]), 64'(exp_upd[d]));
      end
    end
  end

  task automatic cyc(input bit c, input bit w, input bit r, input int f, input int i, input int j);
    clr = c; wr = w; rd = r;
    nf = 32'(f); ni = 16'(i); nj = 16'(j);
    @(posedge CLK); #1;
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic ins(input int f, input int i, input int j);
    cyc(1'b0, 1'b1, 1'b0, f, i, j);
  endtask

  task automatic pop();
    cyc(1'b0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic clear();
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  int ef [5] = '{2, 3, 12, 12, 14};
  int ei [5] = '{1, 2, 5, 4, 6};

  initial begin
    RSTn = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0;
    nf = '0; ni = '0; nj = '0;
    @(posedge CLK); #1;
    chk("rst_empty", 64'(emp[0]), 64'(1));
    chk("rst_count", 64'(cnt_a), 64'(0));
    chk("rst_head_f", 64'(hf[0]), 64'(0));
    #3 RSTn = 1'b1;
    run_cmp = 1'b1;
    @(posedge CLK); #1;

    // sorted insertion and ordered pops
    ins(12, 5, 5); ins(1, 3, 3); ins(2, 1, 1); ins(14, 6, 6); ins(12, 4, 4); ins(3, 2, 2);
    chk("t1_count", 64'(cnt_a), 64'(6));
    chk("t1_head_f", 64'(hf[0]), 64'(1));
    chk("t1_head_i", 64'(hi[0]), 64'(3));
    for (int k = 0; k < 5; k++) begin
      pop();
      chk($sformatf("t1_pop%0d_f", k), 64'(hf[0]), 64'(ef[k]));
      chk($sformatf("t1_pop%0d_i", k), 64'(hi[0]), 64'(ei[k]));
    end
    pop();
    chk("t1_final_empty", 64'(emp[0]), 64'(1));

    // decrease-key then rejected higher-cost duplicate
    ins(14, 6, 6); ins(2, 1, 1); ins(10, 6, 6);
    chk("t2_updated", 64'(upd[0]), 64'(1));
    chk("t2_upd_nodrop", 64'(drp[0]), 64'(0));
    chk("t2_upd_count", 64'(cnt_a), 64'(2));
    ins(20, 1, 1);
    chk("t2_drop", 64'(drp[0]), 64'(1));
    chk("t2_drop_noupd", 64'(upd[0]), 64'(0));
    chk("t2_drop_count", 64'(cnt_a), 64'(2));
    chk("t2_head_f", 64'(hf[0]), 64'(2));
    pop();
    chk("t2_second_f", 64'(hf[0]), 64'(10));
    chk("t2_second_i", 64'(hi[0]), 64'(6));
    pop();
    chk("t2_empty", 64'(emp[0]), 64'(1));

    // full behaviour on the 4-deep instance
    clear();
    ins(5, 10, 10); ins(6, 11, 11); ins(7, 12, 12); ins(8, 13, 13);
    ins(1, 1, 1);
    chk("t3_full_drop", 64'(drp[1]), 64'(1));
    chk("t3_full_flag", 64'(full[1]), 64'(1));
    chk("t3_full_head", 64'(hf[1]), 64'(5));
    cyc(1'b0, 1'b1, 1'b1, 1, 1, 1);
    chk("t3_swap_head", 64'(hf[1]), 64'(1));
    chk("t3_swap_count", 64'(cnt_b), 64'(4));
    chk("t3_swap_nodrop", 64'(drp[1]), 64'(0));
    pop(); chk("t3_pop_6", 64'(hf[1]), 64'(6));
    pop(); chk("t3_pop_7", 64'(hf[1]), 64'(7));
    pop(); chk("t3_pop_8", 64'(hf[1]), 64'(8));
    pop(); chk("t3_empty", 64'(emp[1]), 64'(1));

    // reads against an empty queue
    clear();
    pop();
    chk("t4_count", 64'(cnt_a), 64'(0));
    chk("t4_nodrop", 64'(drp[0]), 64'(0));
    chk("t4_noupd", 64'(upd[0]), 64'(0));
    chk("t4_empty", 64'(emp[0]), 64'(1));
    cyc(1'b0, 1'b1, 1'b1, 9, 9, 9);
    chk("t4_rw_count", 64'(cnt_a), 64'(1));
    chk("t4_rw_head", 64'(hf[0]), 64'(9));

    // asynchronous reset takes effect between edges, then synchronous clear
    ins(3, 3, 3); ins(4, 4, 4);
    chk("t5_pre_count", 64'(cnt_a), 64'(3));
    #1 RSTn = 1'b0;
    #1;
    chk("t5_async_empty", 64'(emp[0]), 64'(1));
    chk("t5_async_count", 64'(cnt_a), 64'(0));
    chk("t5_async_f", 64'(hf[0]), 64'(0));
    chk("t5_async_i", 64'(hi[0]), 64'(0));
    chk("t5_async_j", 64'(hj[0]), 64'(0));
    #1 RSTn = 1'b1;
    @(posedge CLK); #1;
    ins(7, 1, 2); ins(5, 2, 1); ins(6, 3, 1);
    chk("t5_refill", 64'(cnt_a), 64'(3));
    clear();
    chk("t5_clear_empty", 64'(emp[0]), 64'(1));
    chk("t5_clear_count", 64'(cnt_a), 64'(0));
    chk("t5_clear_nodrop", 64'(drp[0]), 64'(0));

    // duplicates kept when dedup is disabled
    ins(4, 2, 2); ins(4, 2, 2);
    chk("t6_count", 64'(cnt_c), 64'(2));
    chk("t6_nodrop", 64'(drp[2]), 64'(0));
    chk("t6_dedup_drop", 64'(drp[0]), 64'(1));
    chk("t6_first_f", 64'(hf[2]), 64'(4));
    pop();
    chk("t6_second_f", 64'(hf[2]), 64'(4));
    chk("t6_second_count", 64'(cnt_c), 64'(1));
    pop();
    chk("t6_empty", 64'(emp[2]), 64'(1));

    repeat (2) @(posedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
